scemi_out_pipe_packer: RTL

- Sits directly upstream of the SCE-MI output pipe.
- Collects a stream of fixed-width elements from the DUT-side producer and packs them into one payload word, element 0 in the LSBs.
- Presents complete messages (data, element count, end-of-message flag) to the pipe send side over a valid/ready handshake.
- Issues partial messages on end-of-message, an explicit flush, or an idle timeout.

---
 rtl/scemi_out_pipe_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/scemi_out_pipe_packer.sv
// Packs fixed-width producer elements into one payload word for the SCE-MI output pipe.
// Messages leave when full, on end-of-message, on flush, or after an idle timeout.
//
// state  | meaning
// S_FILL | accepting elements into the payload slots
// S_SEND | holding a complete message until the pipe takes it
module scemi_out_pipe_packer #(
    parameter int BYTES_PER_ELEMENT    = 1,
    parameter int PAYLOAD_MAX_ELEMENTS = 4,
    parameter int FLUSH_TIMEOUT        = 0,
    localparam int EW                  = BYTES_PER_ELEMENT * 8,
    localparam int PAYLOAD_MAX_BITS    = PAYLOAD_MAX_ELEMENTS * EW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EW-1:0]               in_data,
    input  logic                        in_eom,
    input  logic                        flush_req,
    output logic                        flush_ack,
    output logic                        send_valid,
    input  logic                        send_ready,
    output logic [PAYLOAD_MAX_BITS-1:0] send_data,
    output logic [31:0]                 send_num_elements,
    output logic                        send_eom
);

    localparam int CW = $clog2(PAYLOAD_MAX_ELEMENTS + 1);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 2);
    localparam logic [CW-1:0] LAST_SLOT = CW'(PAYLOAD_MAX_ELEMENTS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

    typedef enum logic {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               count_q, count_d;
    logic [PAYLOAD_MAX_BITS-1:0] payload_q, payload_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic                        pend_q, pend_d;
    logic                        eom_q, eom_d;
    logic                        empty_ack_q, empty_ack_d;

    logic accept;
    logic handshake;
    logic go_full, go_eom, go_flush, go_tmo;

    assign in_ready  = (state_q == S_FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign handshake = (state_q == S_SEND) && send_ready && !rst;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        payload_d   = payload_q;
        tmo_d       = tmo_q;
        pend_d      = pend_q;
        eom_d       = eom_q;
        empty_ack_d = 1'b0;
        go_full     = 1'b0;
        go_eom      = 1'b0;
        go_flush    = 1'b0;
        go_tmo      = 1'b0;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int i = 0; i < PAYLOAD_MAX_ELEMENTS; i++) begin
                        if (count_q == CW'(i)) begin
                            payload_d[i*EW +: EW] = in_data;
                        end
                    end
                    count_d = count_q + CW'(1);
                    tmo_d   = '0;
                end else if (count_q != '0) begin
                    tmo_d = tmo_q + TW'(1);
                end else begin
                    tmo_d = '0;
                end

                go_full  = accept && (count_q == LAST_SLOT);
                go_eom   = accept && in_eom;
                go_flush = flush_req && ((count_q != '0) || accept);
                go_tmo   = (FLUSH_TIMEOUT > 0) && (count_q != '0) && !accept
                           && (tmo_q == TMO_LAST);

                // nothing buffered: acknowledge the flush without a message
                if (flush_req && (count_q == '0) && !accept) begin
                    empty_ack_d = 1'b1;
                end
                if (go_eom) begin
                    eom_d = 1'b1;
                end
                if (go_flush) begin
                    pend_d = 1'b1;
                end
                if (go_full || go_eom || go_flush || go_tmo) begin
                    state_d = S_SEND;
                    tmo_d   = '0;
                end
            end

            S_SEND: begin
                if (flush_req) begin
                    pend_d = 1'b1;
                end
                if (send_ready) begin
                    payload_d = '0;
                    count_d   = '0;
                    eom_d     = 1'b0;
                    pend_d    = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_FILL;
                end
            end

            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            payload_q   <= '0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            eom_q       <= 1'b0;
            empty_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            payload_q   <= payload_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            eom_q       <= eom_d;
            empty_ack_q <= empty_ack_d;
        end
    end

    // a flush arriving on the handshake cycle rides along with that message
    assign flush_ack         = empty_ack_q || (handshake && (pend_q || flush_req));
    assign send_valid        = (state_q == S_SEND);
    assign send_data         = payload_q;
    assign send_num_elements = {{(32-CW){1'b0}}, count_q};
    assign send_eom          = eom_q;

endmodule
